// File: rtl/alu_div_issue_ctrl_if.sv
// Bundle between the divider issue controller and its neighbours: EX request side,
// divider operand/handshake side, and result consumer side.
interface alu_div_issue_ctrl_if #(
  parameter int C_WIDTH     = 32,
  parameter int C_LOG_WIDTH = 6
);
  logic                   ReqVld_SI;
  logic                   ReqRdy_SO;
  logic [C_WIDTH-1:0]     ReqOpA_DI;
  logic [C_WIDTH-1:0]     ReqOpB_DI;
  logic [1:0]             ReqOpCode_DI;
  logic [C_WIDTH-1:0]     OpA_DO;
  logic [C_WIDTH-1:0]     OpB_DO;
  logic [C_LOG_WIDTH-1:0] OpBShift_DO;
  logic                   OpBIsZero_SO;
  logic                   OpBSign_SO;
  logic [1:0]             OpCode_SO;
  logic                   InVld_SO;
  logic                   OutVld_SI;
  logic                   OutRdy_SO;
  logic [C_WIDTH-1:0]     Res_DI;
  logic                   ResVld_SO;
  logic                   ResRdy_SI;
  logic [C_WIDTH-1:0]     Res_DO;
  logic                   Err_SO;
  logic [15:0]            IssueCnt_DO;

  modport master (
    input  ReqVld_SI, ReqOpA_DI, ReqOpB_DI, ReqOpCode_DI, OutVld_SI, Res_DI, ResRdy_SI,
    output ReqRdy_SO, OpA_DO, OpB_DO, OpBShift_DO, OpBIsZero_SO, OpBSign_SO, OpCode_SO,
           InVld_SO, OutRdy_SO, ResVld_SO, Res_DO, Err_SO, IssueCnt_DO
  );

  modport slave (
    output ReqVld_SI, ReqOpA_DI, ReqOpB_DI, ReqOpCode_DI, OutVld_SI, Res_DI, ResRdy_SI,
    input  ReqRdy_SO, OpA_DO, OpB_DO, OpBShift_DO, OpBIsZero_SO, OpBSign_SO, OpCode_SO,
           InVld_SO, OutRdy_SO, ResVld_SO, Res_DO, Err_SO, IssueCnt_DO
  );
endinterface

// File: rtl/alu_div_issue_ctrl.sv
// Issue controller for the serial divider: captures one request, precomputes side-band
// operands, pulses InVld, collects the result and buffers it, with a response watchdog.
//   state | meaning
//   IDLE  | ready for a request from EX
//   ISSUE | single-cycle InVld pulse to the divider
//   WAIT  | waiting for OutVld, watchdog running
//   DONE  | result held for the consumer
module alu_div_issue_ctrl #(
  parameter int C_WIDTH     = 32,
  parameter int C_LOG_WIDTH = 6,
  parameter int C_TIMEOUT   = 48
) (
  input logic                  Clk_CI,
  input logic                  Rst_RI,
  alu_div_issue_ctrl_if.master Bus_S
);

  localparam int CNT_W = $clog2(C_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e                 state_q;
  logic                   req_rdy_q, in_vld_q, out_rdy_q, res_vld_q, err_q;
  logic [C_WIDTH-1:0]     op_a_q, op_b_q, res_q;
  logic [1:0]             op_code_q;
  logic [C_LOG_WIDTH-1:0] shift_q;
  logic                   zero_q, sign_q;
  logic [15:0]            issue_cnt_q;
  logic [CNT_W-1:0]       cnt_q;

  logic                   sign_d, zero_d;
  logic [C_WIDTH-1:0]     x_d;
  logic [C_LOG_WIDTH-1:0] shift_d;

  // Leading-zero count; the highest set bit is visited last and wins.
  always_comb begin
    sign_d  = Bus_S.ReqOpCode_DI[0] & Bus_S.ReqOpB_DI[C_WIDTH-1];
    zero_d  = (Bus_S.ReqOpB_DI == '0);
    x_d     = sign_d ? ~Bus_S.ReqOpB_DI : Bus_S.ReqOpB_DI;
    shift_d = C_LOG_WIDTH'(C_WIDTH);
    for (int i = 0; i < C_WIDTH; i++) begin
      if (x_d[i]) shift_d = C_LOG_WIDTH'(C_WIDTH - 1 - i);
    end
  end

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      state_q     <= IDLE;
      req_rdy_q   <= 1'b0;
      in_vld_q    <= 1'b0;
      out_rdy_q   <= 1'b0;
      res_vld_q   <= 1'b0;
      err_q       <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_code_q   <= '0;
      shift_q     <= '0;
      zero_q      <= 1'b0;
      sign_q      <= 1'b0;
      res_q       <= '0;
      issue_cnt_q <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          req_rdy_q <= 1'b1;
          // Ready is registered, so the first cycle after reset never accepts.
          if (Bus_S.ReqVld_SI && req_rdy_q) begin
            op_a_q    <= Bus_S.ReqOpA_DI;
            op_b_q    <= Bus_S.ReqOpB_DI;
            op_code_q <= Bus_S.ReqOpCode_DI;
            shift_q   <= shift_d;
            zero_q    <= zero_d;
            sign_q    <= sign_d;
            req_rdy_q <= 1'b0;
            in_vld_q  <= 1'b1;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          in_vld_q  <= 1'b0;
          out_rdy_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= WAIT;
        end
        WAIT: begin
          if (Bus_S.OutVld_SI) begin
            res_q       <= Bus_S.Res_DI;
            issue_cnt_q <= issue_cnt_q + 16'd1;
            out_rdy_q   <= 1'b0;
            res_vld_q   <= 1'b1;
            state_q     <= DONE;
          end else if (cnt_q == CNT_W'(C_TIMEOUT - 1)) begin
            err_q     <= 1'b1;
            out_rdy_q <= 1'b0;
            req_rdy_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (Bus_S.ResRdy_SI) begin
            res_vld_q <= 1'b0;
            req_rdy_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Bus_S.ReqRdy_SO    = req_rdy_q;
  assign Bus_S.OpA_DO       = op_a_q;
  assign Bus_S.OpB_DO       = op_b_q;
  assign Bus_S.OpBShift_DO  = shift_q;
  assign Bus_S.OpBIsZero_SO = zero_q;
  assign Bus_S.OpBSign_SO   = sign_q;
  assign Bus_S.OpCode_SO    = op_code_q;
  assign Bus_S.InVld_SO     = in_vld_q;
  assign Bus_S.OutRdy_SO    = out_rdy_q;
  assign Bus_S.ResVld_SO    = res_vld_q;
  assign Bus_S.Res_DO       = res_q;
  assign Bus_S.Err_SO       = err_q;
  assign Bus_S.IssueCnt_DO  = issue_cnt_q;

endmodule
